// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_LSL = 4'b1000;
    localparam logic [3:0] OP_LSR = 4'b1001;
    localparam logic [3:0] OP_ASR = 4'b1010;

    // Bit positions inside the {N,Z,C,V} nibble.
    localparam int unsigned FN = 3;
    localparam int unsigned FZ = 2;
    localparam int unsigned FC = 1;
    localparam int unsigned FV = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits kept.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy     = (cnt_q != '0);
    assign done     = (cnt_q == CW'(1));
    // On the final step the accumulated value including this step is the product.
    assign product  = acc_next;

    // Load operands on start, then add/shift once per cycle while the counter runs down.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
        end else if (busy) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready operand and result handshakes and a persistent NZCV register.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic [3:0]       flags
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       aluflags_q;
    logic [3:0]       flags_q;
    logic             setf_q;

    logic             accept;
    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [3:0]       mul_flags;

    logic [WIDTH-1:0] dp_res;
    logic [3:0]       dp_flags;

    assign accept    = in_ready && in_valid;
    assign mul_start = accept && (ALUControl == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign mul_flags = {mul_product[WIDTH-1], mul_product == '0, 2'b00};

    // Single-cycle datapath: adder with carry-in, logic, barrel shifts and NZCV generation.
    always_comb begin
        logic [WIDTH-1:0] b_eff;
        logic             cin;
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   shl;
        logic [WIDTH:0]   shr;
        logic [SHW-1:0]   sh;
        logic             c, v;

        b_eff  = ALUControl[0] ? ~b : b;
        unique case (ALUControl)
            OP_SUB:         cin = 1'b1;
            OP_ADC, OP_SBC: cin = flags_q[FC];
            default:        cin = 1'b0;
        endcase
        // SUB/SBC share the inverted-b path: ADD=0000, SUB=0001, ADC=0101, SBC=0110.
        if (ALUControl == OP_SBC) begin
            b_eff = ~b;
        end else if (ALUControl == OP_ADC) begin
            b_eff = b;
        end
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        sh     = b[SHW-1:0];
        // Extra bit below/above the word catches the last bit shifted out (0 for amount 0).
        shl    = {1'b0, a} << sh;
        shr    = (ALUControl == OP_ASR) ? $unsigned($signed({a, 1'b0}) >>> sh)
                                        : ({a, 1'b0} >> sh);
        dp_res = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                dp_res = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                // Same effective operand signs, different result sign.
                v      = ~(a[WIDTH-1] ^ b_eff[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND: dp_res = a & b;
            OP_OR:  dp_res = a | b;
            OP_XOR: dp_res = a ^ b;
            OP_LSL: begin
                dp_res = shl[WIDTH-1:0];
                c      = shl[WIDTH];
            end
            OP_LSR, OP_ASR: begin
                dp_res = shr[WIDTH:1];
                c      = shr[0];
            end
            default: dp_res = '0;
        endcase
        dp_flags     = 4'b0000;
        dp_flags[FN] = dp_res[WIDTH-1];
        dp_flags[FZ] = (dp_res == '0);
        dp_flags[FC] = c;
        dp_flags[FV] = v;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !mul_busy;
                if (in_valid && !mul_busy) begin
                    state_d = (ALUControl == OP_MUL) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, result/flag capture and flag-register update on result consumption.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            result_q   <= '0;
            aluflags_q <= '0;
            flags_q    <= '0;
            setf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                setf_q <= set_flags;
                if (ALUControl != OP_MUL) begin
                    result_q   <= dp_res;
                    aluflags_q <= dp_flags;
                end
            end
            if (state_q == BUSY && mul_done) begin
                result_q   <= mul_product;
                aluflags_q <= mul_flags;
            end
            if (state_q == DONE && out_ready && setf_q) begin
                flags_q <= aluflags_q;
            end
        end
    end

    assign Result   = result_q;
    assign ALUFlags = aluflags_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic [3:0]  alu_ctl;
    logic        set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  alu_flags;
    logic [3:0]  flags;

    int total_cnt = 0;
    int pass_cnt  = 0;

    alu_mc #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUControl (alu_ctl),
        .set_flags  (set_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (result),
        .ALUFlags   (alu_flags),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] va;
        logic [15:0] vb;
        logic        sf;
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb,
                       input logic sf, input logic [15:0] res, input logic [3:0] fl,
                       input int lat);
        vec_t v;
        v.op = op; v.va = va; v.vb = vb; v.sf = sf; v.res = res; v.fl = fl; v.lat = lat;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at a negedge; accept happens at the following posedge.
    task automatic issue(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb,
                         input logic sf, input string name);
        in_valid = 1'b1; alu_ctl = op; a = va; b = vb; set_flags = sf;
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; alu_ctl = 4'b0011; set_flags = ~sf;
    endtask

    // Returns cycles from accept edge to first cycle with out_valid; flags in_ready while waiting.
    task automatic wait_result(output int lat, output bit ready_seen);
        lat = 0;
        ready_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) ready_seen = 1'b1;
        end while (!out_valid && lat < 200);
    endtask

    // Consume the result at the next posedge, end at the following negedge.
    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
        check({name, " in_ready back"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [3:0] exp_flags;

    initial begin
        int  lat;
        bit  rdy;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; alu_ctl = '0; set_flags = 1'b0;

        //   op       a        b        sf    Result   NZCV     latency
        add(4'b0000, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1001, 1);
        add(4'b0001, 16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b0110, 1);
        add(4'b0110, 16'h0000, 16'h0000, 1'b1, 16'h0000, 4'b0110, 1);
        add(4'b0101, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0110, 1);
        add(4'b0101, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 4'b0110, 1);
        add(4'b0000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1001, 1);
        add(4'b0111, 16'h0123, 16'h0045, 1'b1, 16'h4E6F, 4'b0000, 17);
        add(4'b0101, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 4'b1000, 1);
        add(4'b1010, 16'h8001, 16'h0011, 1'b1, 16'hC000, 4'b1010, 1);
        add(4'b1000, 16'h0001, 16'h0000, 1'b1, 16'h0001, 4'b0000, 1);
        add(4'b1001, 16'h8000, 16'h000F, 1'b0, 16'h0001, 4'b0000, 1);
        add(4'b0010, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 4'b0000, 1);
        add(4'b0011, 16'h8000, 16'h0001, 1'b0, 16'h8001, 4'b1000, 1);
        add(4'b0100, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 4'b0100, 1);
        add(4'b1000, 16'h8001, 16'h0001, 1'b1, 16'h0002, 4'b0010, 1);
        add(4'b0110, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1000, 1);
        add(4'b0001, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0011, 1);
        add(4'b0000, 16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b0111, 1);
        add(4'b0111, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 4'b0000, 17);
        add(4'b0111, 16'h0000, 16'h1234, 1'b0, 16'h0000, 4'b0100, 17);
        add(4'b1111, 16'h1234, 16'h5678, 1'b1, 16'h0000, 4'b0100, 1);
        add(4'b0101, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 1);
        add(4'b1010, 16'h7FFF, 16'h000F, 1'b0, 16'h0000, 4'b0110, 1);
        add(4'b1001, 16'h8001, 16'h0010, 1'b0, 16'h8001, 4'b1000, 1);
        add(4'b1011, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 4'b0100, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset Result", {16'd0, result}, 32'd0);
        check("reset ALUFlags", {28'd0, alu_flags}, 32'd0);
        check("reset flags", {28'd0, flags}, 32'd0);
        reset = 1'b0;
        exp_flags = 4'b0000;

        foreach (vq[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(vq[i].op, vq[i].va, vq[i].vb, vq[i].sf, nm);
            wait_result(lat, rdy);
            check({nm, " latency"}, lat, vq[i].lat);
            if (vq[i].lat > 1) check({nm, " in_ready while busy"}, {31'd0, rdy}, 32'd0);
            check({nm, " Result"}, {16'd0, result}, {16'd0, vq[i].res});
            check({nm, " ALUFlags"}, {28'd0, alu_flags}, {28'd0, vq[i].fl});
            handshake(nm);
            if (vq[i].sf) exp_flags = vq[i].fl;
            check({nm, " flags"}, {28'd0, flags}, {28'd0, exp_flags});
        end

        // Backpressure: result held, new in_valid ignored while DONE.
        issue(4'b0000, 16'h1234, 16'h1111, 1'b1, "bp");
        wait_result(lat, rdy);
        in_valid = 1'b1; alu_ctl = 4'b0001; a = 16'h0001; b = 16'h0002; set_flags = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp out_valid held", {31'd0, out_valid}, 32'd1);
            check("bp in_ready low", {31'd0, in_ready}, 32'd0);
            check("bp Result stable", {16'd0, result}, 32'h2345);
            check("bp ALUFlags stable", {28'd0, alu_flags}, 32'd0);
        end
        in_valid = 1'b0;
        handshake("bp");
        check("bp flags", {28'd0, flags}, 32'd0);

        // Flag update at handshake m feeds an ADC accepted at m+1.
        issue(4'b0001, 16'h0005, 16'h0005, 1'b1, "fwd sub");
        wait_result(lat, rdy);
        handshake("fwd sub");
        issue(4'b0101, 16'h0000, 16'h0000, 1'b0, "fwd adc");
        wait_result(lat, rdy);
        check("fwd adc Result", {16'd0, result}, 32'h0001);
        handshake("fwd adc");

        // Reset during MUL busy aborts and clears flags.
        check("abort pre flags", {28'd0, flags}, 32'h6);
        issue(4'b0111, 16'h0123, 16'h0045, 1'b1, "abort");
        repeat (5) @(negedge clk);
        check("abort busy in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort flags", {28'd0, flags}, 32'd0);
        check("abort Result", {16'd0, result}, 32'd0);
        repeat (20) begin
            @(negedge clk);
            check("abort no late result", {31'd0, out_valid}, 32'd0);
        end
        issue(4'b0000, 16'h0002, 16'h0003, 1'b0, "recover");
        wait_result(lat, rdy);
        check("recover latency", lat, 1);
        check("recover Result", {16'd0, result}, 32'h0005);
        handshake("recover");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
